// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single memory port between the instruction-fetch
// and load/store requesters. One access at a time, round-robin on ties,
// registered command and response, and a bounded wait on mem_ready.
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [DATA_WIDTH-1:0] if_addr,
    output logic                  if_ack,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_err,
    input  logic                  d_req,
    input  logic                  d_store,
    input  logic [DATA_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [1:0]            d_len,
    input  logic                  d_unsigned,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_err,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [1:0]            mem_len,
    output logic                  mem_unsigned,
    output logic                  mem_load,
    output logic                  mem_store,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    // Last BUSY cycle index before the access is abandoned.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t                state_q;
    logic                  last_grant_q;   // 0 = fetch, 1 = data
    logic                  owner_q;        // 0 = fetch, 1 = data
    logic [7:0]            wait_cnt_q;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_wdata_q;
    logic [1:0]            mem_len_q;
    logic                  mem_unsigned_q, mem_load_q, mem_store_q;
    logic                  if_ack_q, if_err_q, d_ack_q, d_err_q;
    logic [DATA_WIDTH-1:0] if_rdata_q, d_rdata_q;
    logic                  grant_data_d;

    // Data wins when it is alone, or on a tie when fetch was granted last.
    always_comb begin
        grant_data_d = d_req && (!if_req || !last_grant_q);
    end

    // Arbiter FSM; every output is a register written here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            last_grant_q   <= 1'b0;
            owner_q        <= 1'b0;
            wait_cnt_q     <= '0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_len_q      <= '0;
            mem_unsigned_q <= 1'b0;
            mem_load_q     <= 1'b0;
            mem_store_q    <= 1'b0;
            if_ack_q       <= 1'b0;
            if_err_q       <= 1'b0;
            if_rdata_q     <= '0;
            d_ack_q        <= 1'b0;
            d_err_q        <= 1'b0;
            d_rdata_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (if_req || d_req) begin
                        state_q      <= S_BUSY;
                        owner_q      <= grant_data_d;
                        last_grant_q <= grant_data_d;
                        wait_cnt_q   <= '0;
                        if (grant_data_d) begin
                            mem_addr_q     <= d_addr;
                            mem_wdata_q    <= d_wdata;
                            mem_len_q      <= d_len;
                            mem_unsigned_q <= d_unsigned;
                            mem_load_q     <= !d_store;
                            mem_store_q    <= d_store;
                        end else begin
                            // Fetch is always an unsigned-agnostic full-word read.
                            mem_addr_q     <= if_addr;
                            mem_wdata_q    <= '0;
                            mem_len_q      <= 2'd3;
                            mem_unsigned_q <= 1'b0;
                            mem_load_q     <= 1'b1;
                            mem_store_q    <= 1'b0;
                        end
                    end
                end
                S_BUSY: begin
                    wait_cnt_q <= wait_cnt_q + 8'd1;
                    // mem_ready is checked first so it beats a same-cycle timeout.
                    if (mem_ready || (wait_cnt_q == WAIT_LAST)) begin
                        state_q     <= S_RESP;
                        mem_load_q  <= 1'b0;
                        mem_store_q <= 1'b0;
                        if (owner_q) begin
                            d_ack_q   <= 1'b1;
                            d_err_q   <= !mem_ready;
                            d_rdata_q <= (mem_ready && !mem_store_q) ? mem_rdata : '0;
                        end else begin
                            if_ack_q   <= 1'b1;
                            if_err_q   <= !mem_ready;
                            if_rdata_q <= mem_ready ? mem_rdata : '0;
                        end
                    end
                end
                S_RESP: begin
                    state_q    <= S_IDLE;
                    if_ack_q   <= 1'b0;
                    if_err_q   <= 1'b0;
                    if_rdata_q <= '0;
                    d_ack_q    <= 1'b0;
                    d_err_q    <= 1'b0;
                    d_rdata_q  <= '0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign if_ack       = if_ack_q;
    assign if_rdata     = if_rdata_q;
    assign if_err       = if_err_q;
    assign d_ack        = d_ack_q;
    assign d_rdata      = d_rdata_q;
    assign d_err        = d_err_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_len      = mem_len_q;
    assign mem_unsigned = mem_unsigned_q;
    assign mem_load     = mem_load_q;
    assign mem_store    = mem_store_q;

endmodule
